interval_timer_ctrl: RTL

- Control stage that sits directly around the free-running N-bit counter.
- Consumes the counter's count value and drives its synchronous resetcount input to produce programmable periodic or one-shot ticks.
- Provides a sticky interrupt flag for the CPU-side logic.
- Turns the bare counter into a usable timer peripheral for the 8-bit core.

---
 rtl/interval_timer_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/interval_timer_ctrl.sv
// Control stage around a free-running counter: drives its synchronous clear to make periodic or
// one-shot ticks plus a sticky irq. Define TIMER_MISS_CNT_EN to add the miss_cnt output.
module interval_timer_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] count,
    output logic             resetcount,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             irq_ack,
    output logic             tick,
    output logic             irq,
    output logic             busy,
`ifdef TIMER_MISS_CNT_EN
    output logic [7:0]       miss_cnt,
`endif
    output logic [CNT_W-1:0] cur_period
);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] shadow_q;
    logic             shadow_valid_q;
    logic             mode_q;
    logic             tick_q;
    logic             irq_q;
    logic             busy_q;
    logic             terminal;

    assign terminal = (state_q == StRun) && (count == period_q);

    // Counter is parked at 0 while idle or arming, and wrapped at the terminal count.
    always_comb begin
        resetcount = (state_q == StIdle) || (state_q == StArm) || terminal;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            period_q       <= '1;
            shadow_q       <= '1;
            shadow_valid_q <= 1'b0;
            mode_q         <= 1'b0;
            tick_q         <= 1'b0;
            irq_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            irq_q  <= tick_q | (irq_q & ~irq_ack);
            unique case (state_q)
                StIdle, StDone: begin
                    if (load) begin
                        period_q       <= load_value;
                        shadow_valid_q <= 1'b0;
                    end
                    if (start && !stop) begin
                        state_q <= StArm;
                        mode_q  <= periodic;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StArm: begin
                    if (load) begin
                        shadow_q       <= load_value;
                        shadow_valid_q <= 1'b1;
                    end
                    if (stop) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (terminal) begin
                        tick_q <= 1'b1;
                        // Swap only at the wrap so the new period never lies behind the count.
                        if (shadow_valid_q) begin
                            period_q <= shadow_q;
                        end
                        if (!mode_q) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                        end
                    end
                    if (load) begin
                        shadow_q       <= load_value;
                        shadow_valid_q <= 1'b1;
                    end else if (terminal && !stop) begin
                        shadow_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIMER_MISS_CNT_EN
    logic [7:0] miss_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miss_q <= 8'd0;
        end else if (irq_ack) begin
            miss_q <= 8'd0;
        end else if (tick_q && irq_q && (miss_q != 8'hff)) begin
            miss_q <= miss_q + 8'd1;
        end
    end

    assign miss_cnt = miss_q;
`endif

    assign tick       = tick_q;
    assign irq        = irq_q;
    assign busy       = busy_q;
    assign cur_period = period_q;

endmodule
